// File: rtl/trace_pkg.sv
// Shared types for the writeback trace path: the queued event record and its sequence width.
package trace_pkg;

    localparam int unsigned TRACE_SEQ_W = 16;

    typedef struct packed {
        logic [31:0]            pc;
        logic [4:0]             addr;
        logic [31:0]            data;
        logic [TRACE_SEQ_W-1:0] seq;
    } trace_entry_t;

    localparam int unsigned TRACE_ENTRY_W = $bits(trace_entry_t);

    function automatic logic [TRACE_SEQ_W-1:0] sat_inc(input logic [TRACE_SEQ_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count; refuses pushes when full and pops when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FullCnt);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Pointers are exactly AW bits, so the increment wraps modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// Queues qualifying register writebacks with sequence numbers for the trace logger;
// events arriving while full are dropped and accounted for.
module wb_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_en,
    input  logic [4:0]             wb_addr,
    input  logic [31:0]            wb_data,
    input  logic [31:0]            wb_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_pc,
    output logic [4:0]             out_addr,
    output logic [31:0]            out_data,
    output logic [TRACE_SEQ_W-1:0] out_seq,
    output logic                   overflow,
    output logic [15:0]            drop_cnt
);

    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

    logic [TRACE_SEQ_W-1:0] seq_q, seq_d;
    logic [15:0]            drop_cnt_q, drop_cnt_d;
    logic                   overflow_q, overflow_d;

    logic         qual, push, pop, drop;
    logic         fifo_full, fifo_empty;
    logic [AW:0]  fifo_count;
    trace_entry_t wr_entry, head;

    assign qual = wb_en && (wb_addr != 5'd0);
    assign pop  = out_valid && out_ready;
    assign push = qual && (!fifo_full || pop);
    assign drop = qual && !pop && (fifo_count == FullCnt);

    assign wr_entry = '{pc: wb_pc, addr: wb_addr, data: wb_data, seq: seq_q};

    sync_fifo #(
        .WIDTH (TRACE_ENTRY_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_pc    = head.pc;
    assign out_addr  = head.addr;
    assign out_data  = head.data;
    assign out_seq   = head.seq;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

    // Dropped events still consume a sequence number so the logger sees the gap.
    always_comb begin
        seq_d      = seq_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (qual) seq_d = seq_q + 1'b1;
        if (drop) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_q      <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            seq_q      <= seq_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed and random stimulus for wb_trace_buffer against a queue-based reference model.
module tb_wb_trace_buffer;
    import trace_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [31:0] wb_pc = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic [15:0] out_seq;
    logic        overflow;
    logic [15:0] drop_cnt;

    wb_trace_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_pc     (wb_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .out_seq   (out_seq),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model: a plain queue of pending events plus the counters the logger sees.
    trace_entry_t mq[$];
    logic [15:0]  m_seq  = '0;
    logic [15:0]  m_drop = '0;
    logic         m_ovf  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_pc",   out_pc,           mq[0].pc);
            chk("out_addr", 32'(out_addr),    32'(mq[0].addr));
            chk("out_data", out_data,         mq[0].data);
            chk("out_seq",  32'(out_seq),     32'(mq[0].seq));
        end
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model at the rising edge.
    task automatic step(input logic en, input logic [4:0] addr, input logic [31:0] data,
                        input logic [31:0] pc, input logic ready);
        logic do_pop;
        wb_en = en; wb_addr = addr; wb_data = data; wb_pc = pc; out_ready = ready;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        do_pop = (mq.size() != 0) && ready;
        if (do_pop) void'(mq.pop_front());
        if (en && addr != 5'd0) begin
            if (mq.size() < DEPTH) mq.push_back('{pc: pc, addr: addr, data: data, seq: m_seq});
            else begin
                m_ovf = 1'b1;
                if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end
            m_seq = m_seq + 16'd1;
        end
        #1;
    endtask

    task automatic idle(input logic ready);
        step(1'b0, 5'd0, 32'd0, 32'd0, ready);
    endtask

    task automatic event_step(input int unsigned i, input logic ready);
        step(1'b1, 5'(1 + (i % 31)), 32'hA000_0000 + i, 32'h0040_0000 + 4 * i, ready);
    endtask

    // Called just after a rising edge; reset is applied and released between edges.
    task automatic pulse_reset();
        wb_en = 1'b0; out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ovf",   32'(overflow),  32'd0);
        chk("rst_drop",  32'(drop_cnt),  32'd0);
        mq.delete();
        m_seq = '0; m_drop = '0; m_ovf = 1'b0;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #12 rst = 1'b0;
        idle(1'b0);

        // Single event, one-cycle latency, then pop.
        step(1'b1, 5'd5, 32'h1234, 32'h0040_0000, 1'b0);
        chk("tp1_valid", 32'(out_valid), 32'd1);
        chk("tp1_seq",   32'(out_seq),   32'd0);
        idle(1'b1);
        idle(1'b0);

        // $zero writes are ignored and consume no sequence number.
        pulse_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 5'd0, 32'hDEAD, 32'h100 + i, 1'b0);
        step(1'b1, 5'd2, 32'h55, 32'h200, 1'b0);
        chk("tp2_seq", 32'(out_seq), 32'd0);
        idle(1'b1);
        idle(1'b0);

        // Overflow: 20 events into 16 slots, drain, next event gets seq 20.
        pulse_reset();
        for (int i = 0; i < 20; i++) event_step(i, 1'b0);
        chk("tp3_drop", 32'(drop_cnt), 32'd4);
        chk("tp3_ovf",  32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) idle(1'b1);
        event_step(20, 1'b0);
        chk("tp3_seq20", 32'(out_seq), 32'd20);
        idle(1'b1);

        // Full with simultaneous push and pop: no drops, no gaps.
        pulse_reset();
        for (int i = 0; i < 16; i++) event_step(i, 1'b0);
        for (int i = 16; i < 26; i++) event_step(i, 1'b1);
        chk("tp4_drop", 32'(drop_cnt), 32'd0);
        for (int i = 0; i < 17; i++) idle(1'b1);

        // Streaming 100 events with the logger always ready.
        pulse_reset();
        for (int i = 0; i < 100; i++) event_step(i, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Random traffic including $zero writes, stalls and overflow bursts.
        for (int i = 0; i < 600; i++) begin
            step(1'b1 && ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
                 $urandom, ($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < 20; i++) idle(1'b1);

        // Reset in the middle of a backlog drops out_valid without a clock edge.
        pulse_reset();
        for (int i = 0; i < 8; i++) event_step(i, 1'b0);
        chk("tp6_valid_before", 32'(out_valid), 32'd1);
        pulse_reset();
        event_step(50, 1'b0);
        chk("tp6_seq", 32'(out_seq), 32'd0);
        idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
